// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit between EXU and WBU: one op per handshake, valid/ready data-memory bus,
// byte/word load extraction and store lane steering, with a bus timeout and misalignment trap.
module ysyx_25020047_lsu #(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_result,
   input  logic [31:0] in_wdata,
   input  logic        in_read,
   input  logic        in_write,
   input  logic        in_byte,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_q, rd_d;
   logic             byte_q, byte_d;
   logic [1:0]       off_q, off_d;
   logic             wen_q, wen_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wmask_q, wmask_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             err_q, err_d;

   logic accept, is_mem, both_rw, misalign, timeout;

   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic is_byte,
                                                input logic [1:0] off);
      if (is_byte) return {24'b0, rdata[{off, 3'b000} +: 8]};
      return rdata;
   endfunction

   function automatic logic [3:0] lane_mask(input logic is_byte, input logic [1:0] off);
      if (is_byte) return 4'b0001 << off;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] lane_data(input logic is_byte, input logic [31:0] wdata);
      if (is_byte) return {4{wdata[7:0]}};
      return wdata;
   endfunction

   assign accept   = in_valid & in_ready;
   assign is_mem   = in_read | in_write;
   assign both_rw  = in_read & in_write;
   assign misalign = is_mem & ~both_rw & ~in_byte & (in_result[1:0] != 2'b00);
   assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rd_q       <= 1'b0;
         byte_q     <= 1'b0;
         off_q      <= 2'b00;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         byte_q     <= byte_d;
         off_q      <= off_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         out_data_q <= out_data_d;
         err_q      <= err_d;
      end
   end

   // Conflicting read+write, non-memory and misaligned ops all skip the bus.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (both_rw || !is_mem || misalign) state_d = S_DONE;
               else                                state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready) state_d = rd_q ? S_RESP : S_DONE;
            else if (timeout)  state_d = S_DONE;
         end
         S_RESP: begin
            if (mem_resp_valid || timeout) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = '0;
      rd_d       = rd_q;
      byte_d     = byte_q;
      off_d      = off_q;
      wen_d      = wen_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      out_data_d = out_data_q;
      err_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               rd_d       = in_read;
               byte_d     = in_byte;
               off_d      = in_result[1:0];
               wen_d      = in_write;
               addr_d     = {in_result[31:2], 2'b00};
               wdata_d    = lane_data(in_byte, in_wdata);
               wmask_d    = lane_mask(in_byte, in_result[1:0]);
               out_data_d = misalign ? 32'b0 : in_result;
               err_d      = misalign;
            end
         end
         // Counter restarts from zero when the request handshake moves a load into RESP.
         S_REQ: begin
            if (!mem_req_ready) begin
               if (timeout) begin
                  out_data_d = '0;
                  err_d      = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_RESP: begin
            if (mem_resp_valid) begin
               out_data_d = load_extract(mem_resp_rdata, byte_q, off_q);
            end else if (timeout) begin
               out_data_d = '0;
               err_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready      = (state_q == S_IDLE);
      mem_req_valid = (state_q == S_REQ);
      out_valid     = (state_q == S_DONE);
   end

   assign mem_req_wen   = wen_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;
   assign out_data      = out_data_q;
   assign bus_err       = err_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for ysyx_25020047_lsu: a reference memory model predicts bus requests
// and writeback values; a negedge monitor compares them as the DUT presents them.
module tb_ysyx_25020047_lsu;

   localparam int TIMEOUT_CYC = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [31:0] in_wdata;
   logic        in_read;
   logic        in_write;
   logic        in_byte;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wen;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        bus_err;

   ysyx_25020047_lsu #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_wdata(in_wdata),
      .in_read(in_read), .in_write(in_write), .in_byte(in_byte),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   typedef struct {
      logic [31:0] data;
      int          err;
   } out_t;

   req_t        req_q[$];
   out_t        out_q[$];
   req_t        mr;
   out_t        mo;
   logic [31:0] ref_mem [16];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int err_cnt = 0;
   int err_cyc = 0;
   int req_rise_cyc = 0;
   int last_hs_cyc = 0;
   int hs_cnt = 0;
   bit prev_rv = 1'b0;
   bit req_stall = 1'b0;
   bit resp_stall = 1'b0;
   int resp_extra = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: bus requests and writeback values are popped from the scoreboard queues.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus_err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (mem_req_valid === 1'b1 && !prev_rv) req_rise_cyc = cyc;
         if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (req_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
            else begin
               mr = req_q.pop_front();
               check("req_addr", mem_req_addr, mr.addr);
               check("req_wen", {31'b0, mem_req_wen}, {31'b0, mr.wen});
               if (mr.wen) begin
                  check("req_wdata", mem_req_wdata, mr.wdata);
                  check("req_wmask", {28'b0, mem_req_wmask}, {28'b0, mr.wmask});
               end
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (out_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
            else begin
               mo = out_q.pop_front();
               check("out_data", out_data, mo.data);
               check("bus_err_pulses", err_cnt, mo.err);
            end
            err_cnt = 0;
         end
      end
      prev_rv = (mem_req_valid === 1'b1);
   end

   // Bus responder: random ready latency, a decoy response on the request-handshake cycle,
   // then the real response from the reference memory.
   initial begin
      logic [31:0] ra;
      logic        rw;
      int          d;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_resp_valid = 1'b0;
         if (mem_req_valid === 1'b1 && !req_stall) begin
            d = $urandom_range(0, 3);
            repeat (d) begin @(posedge clk); #1; end
            ra = mem_req_addr;
            rw = mem_req_wen;
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = ~ref_mem[ra[5:2]];
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (!rw && !resp_stall) begin
               d = resp_extra + $urandom_range(0, 2);
               repeat (d) begin @(posedge clk); #1; end
               mem_resp_valid = 1'b1;
               mem_resp_rdata = ref_mem[ra[5:2]];
               @(posedge clk); #1;
               mem_resp_valid = 1'b0;
            end
         end
      end
   end

   task automatic do_op(input bit rd, input bit wr, input bit by, input logic [31:0] addr,
                        input logic [31:0] wd, input int ordly);
      out_t        eo;
      req_t        er;
      bit          mem_op, mis;
      int          a, n;
      logic [31:0] w, sd;
      logic [3:0]  sm;
      mem_op = rd | wr;
      mis    = mem_op && !by && (addr[1:0] != 2'b00);
      a      = int'(addr[1:0]);
      w      = ref_mem[addr[5:2]];
      if (!mem_op) begin
         eo = '{addr, 0};
      end else if (mis) begin
         eo = '{32'h0, 1};
      end else if (req_stall || (rd && resp_stall)) begin
         eo = '{32'h0, 1};
         if (!req_stall) begin
            er = '{{addr[31:2], 2'b00}, 1'b0, 32'h0, 4'h0};
            req_q.push_back(er);
         end
      end else if (rd) begin
         eo = '{by ? ((w / (32'd1 << (8 * a))) % 32'd256) : w, 0};
         er = '{{addr[31:2], 2'b00}, 1'b0, 32'h0, 4'h0};
         req_q.push_back(er);
      end else begin
         sm = by ? 4'(1 << a) : 4'hf;
         sd = by ? {4{wd[7:0]}} : wd;
         for (int i = 0; i < 4; i++)
            if (sm[i]) ref_mem[addr[5:2]][8*i +: 8] = sd[8*i +: 8];
         er = '{{addr[31:2], 2'b00}, 1'b1, sd, sm};
         req_q.push_back(er);
         eo = '{addr, 0};
      end
      out_q.push_back(eo);

      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      check("in_ready_wait", {31'b0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_read   = rd;
      in_write  = wr;
      in_byte   = by;
      in_result = addr;
      in_wdata  = wd;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_result = $urandom;
      in_wdata  = $urandom;

      n = 0;
      while (out_valid !== 1'b1 && n < 700) begin @(posedge clk); #1; n++; end
      check("out_valid_wait", {31'b0, out_valid}, 32'd1);
      if (!mem_op || mis) check("nonbus_latency", n, 0);
      if (wr && !rd && !mis && !req_stall) check("store_done_latency", cyc - last_hs_cyc, 1);
      repeat (ordly) begin
         check("hold_out_valid", {31'b0, out_valid}, 32'd1);
         check("hold_out_data", out_data, eo.data);
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_out_in_ready", {31'b0, in_ready}, 32'd1);
      check("post_out_valid", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int          n, bad, h0, kind;
      bit          by;
      logic [31:0] a;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_read   = 1'b0;
      in_write  = 1'b0;
      in_byte   = 1'b0;
      in_result = '0;
      in_wdata  = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;

      repeat (3) begin @(posedge clk); #1; end
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_bus_err", {31'b0, bus_err}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_req_addr", mem_req_addr, 32'd0);
      check("rst_req_wdata", mem_req_wdata, 32'd0);
      check("rst_req_wmask_wen", {27'b0, mem_req_wmask, mem_req_wen}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      ref_mem[1] = 32'hDEADBEEF;
      do_op(1'b1, 1'b0, 1'b0, 32'h8000_0004, 32'h0, 1);
      ref_mem[0] = 32'h12345678;
      do_op(1'b1, 1'b0, 1'b1, 32'h8000_0003, 32'h0, 0);
      do_op(1'b0, 1'b1, 1'b1, 32'h8000_0001, 32'h0000_00AB, 0);
      do_op(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 0);
      do_op(1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 3);
      do_op(1'b1, 1'b0, 1'b0, 32'h8000_0002, 32'h0, 0);
      do_op(1'b0, 1'b1, 1'b0, 32'h8000_0007, 32'h1234_5678, 1);

      req_stall = 1'b1;
      do_op(1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 0);
      check("req_timeout_cycles", err_cyc - req_rise_cyc, TIMEOUT_CYC);
      req_stall = 1'b0;

      resp_stall = 1'b1;
      do_op(1'b1, 1'b0, 1'b1, 32'h8000_0009, 32'h0, 0);
      check("resp_timeout_cycles", err_cyc - last_hs_cyc, TIMEOUT_CYC + 1);
      resp_stall = 1'b0;

      // Reset while a load waits in RESP; its late response must be ignored.
      resp_extra = 6;
      mr = '{32'h8000_0008, 1'b0, 32'h0, 4'h0};
      req_q.push_back(mr);
      h0 = hs_cnt;
      in_valid  = 1'b1;
      in_read   = 1'b1;
      in_write  = 1'b0;
      in_byte   = 1'b0;
      in_result = 32'h8000_0008;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (hs_cnt == h0 && n < 50) begin @(posedge clk); #1; n++; end
      check("rst_test_req_hs", {31'b0, hs_cnt != h0}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("midrst_out_data", out_data, 32'd0);
      out_q.delete();
      err_cnt = 0;
      bad = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) bad++;
      end
      check("stale_resp_ignored", bad, 0);
      resp_extra = 0;
      do_op(1'b1, 1'b0, 1'b0, 32'h8000_0008, 32'h0, 0);

      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 2);
         by   = 1'($urandom_range(0, 1));
         a    = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
         if (by || $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
         if (kind == 0) a = $urandom;
         do_op(kind == 1, kind == 2, by, a, $urandom, $urandom_range(0, 2));
      end

      repeat (5) begin @(posedge clk); #1; end
      check("req_queue_drained", req_q.size(), 0);
      check("out_queue_drained", out_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
